// File: rtl/gpio_ctrl.sv
// gpio_ctrl: register-mapped GPIO controller for a tristate IO bank.
// Drives pad_o / pad_oe straight from registers, synchronizes pad_i,
// detects per-pin rising/falling edges into a sticky write-1-to-clear
// status register, and raises a registered level interrupt.
//
// Register port handshake: a write is accepted at every clk edge where
// we is high. A read is accepted at every clk edge where re is high; the
// data appears on rdata with rvalid = 1 for exactly the following cycle.
// There is no back-pressure, so one read per cycle may be issued. rdata
// holds its last value while rvalid is low.
module gpio_ctrl #(
   parameter int NPINS       = 20,
   parameter int SYNC_STAGES = 2   // must be >= 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       addr,
   input  logic [NPINS-1:0] wdata,
   input  logic             we,
   input  logic             re,
   output logic [NPINS-1:0] rdata,
   output logic             rvalid,
   output logic             irq,
   output logic [NPINS-1:0] pad_o,
   output logic [NPINS-1:0] pad_oe,
   input  logic [NPINS-1:0] pad_i
);

   localparam logic [2:0] A_DATA_OUT   = 3'd0;
   localparam logic [2:0] A_DATA_OE    = 3'd1;
   localparam logic [2:0] A_DATA_IN    = 3'd2;
   localparam logic [2:0] A_RISE_EN    = 3'd3;
   localparam logic [2:0] A_FALL_EN    = 3'd4;
   localparam logic [2:0] A_IRQ_STATUS = 3'd5;

   logic [NPINS-1:0] data_out;
   logic [NPINS-1:0] data_oe;
   logic [NPINS-1:0] rise_en;
   logic [NPINS-1:0] fall_en;
   logic [NPINS-1:0] status;
   logic [NPINS-1:0] sync_q [SYNC_STAGES];
   logic [NPINS-1:0] sync;
   logic [NPINS-1:0] prev;

   logic [NPINS-1:0] rise;
   logic [NPINS-1:0] fall;
   logic [NPINS-1:0] status_set;
   logic [NPINS-1:0] status_clr;
   logic [NPINS-1:0] status_next;
   logic [NPINS-1:0] rd_mux;

   assign sync   = sync_q[SYNC_STAGES-1];
   assign pad_o  = data_out;
   assign pad_oe = data_oe;

   // Multi-flop synchronizer for the asynchronous pad readback.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= pad_i;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   // Edge-history register: last cycle's synchronized pad value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) prev <= '0;
      else     prev <= sync;
   end

   // Edge detection and status update; a set in the same cycle as a clear wins.
   always_comb begin
      rise        = sync & ~prev;
      fall        = ~sync & prev;
      status_set  = (rise & rise_en) | (fall & fall_en);
      status_clr  = '0;
      if (we && addr == A_IRQ_STATUS) status_clr = wdata;
      status_next = (status & ~status_clr) | status_set;
   end

   // Read mux over the pre-write register values; unmapped addresses read 0.
   always_comb begin
      rd_mux = '0;
      case (addr)
         A_DATA_OUT:   rd_mux = data_out;
         A_DATA_OE:    rd_mux = data_oe;
         A_DATA_IN:    rd_mux = sync;
         A_RISE_EN:    rd_mux = rise_en;
         A_FALL_EN:    rd_mux = fall_en;
         A_IRQ_STATUS: rd_mux = status;
         default:      rd_mux = '0;
      endcase
   end

   // Software-writable configuration registers; DATA_IN and 6/7 ignore writes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out <= '0;
         data_oe  <= '0;
         rise_en  <= '0;
         fall_en  <= '0;
      end else if (we) begin
         case (addr)
            A_DATA_OUT: data_out <= wdata;
            A_DATA_OE:  data_oe  <= wdata;
            A_RISE_EN:  rise_en  <= wdata;
            A_FALL_EN:  fall_en  <= wdata;
            default:    ;
         endcase
      end
   end

   // Sticky interrupt status and the registered level interrupt behind it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         status <= '0;
         irq    <= 1'b0;
      end else begin
         status <= status_next;
         irq    <= |status;
      end
   end

   // Registered read port: one-cycle rvalid pulse, rdata held between reads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata  <= '0;
         rvalid <= 1'b0;
      end else begin
         rvalid <= re;
         if (re) rdata <= rd_mux;
      end
   end

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl: directed bench for gpio_ctrl. Reads push their expected
// value into exp_q; a monitor pops and compares whenever rvalid is seen.
// Pin-level outputs (pad_o, pad_oe, irq, rvalid) are checked directly.
module tb_gpio_ctrl;

   localparam int W = 20;

   logic         clk = 1'b0;
   logic         rst;
   logic [2:0]   addr;
   logic [W-1:0] wdata;
   logic         we;
   logic         re;
   logic [W-1:0] rdata;
   logic         rvalid;
   logic         irq;
   logic [W-1:0] pad_o;
   logic [W-1:0] pad_oe;
   logic [W-1:0] pad_i;

   logic [W-1:0] exp_q[$];
   int n_checks = 0;
   int n_errors = 0;

   gpio_ctrl #(.NPINS(W), .SYNC_STAGES(2)) dut (
      .clk    (clk),
      .rst    (rst),
      .addr   (addr),
      .wdata  (wdata),
      .we     (we),
      .re     (re),
      .rdata  (rdata),
      .rvalid (rvalid),
      .irq    (irq),
      .pad_o  (pad_o),
      .pad_oe (pad_oe),
      .pad_i  (pad_i)
   );

   // clock / reset block
   always #5 clk = ~clk;

   // generic comparison
   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%05h expected 0x%05h", name, act, exp);
      end
   endtask

   // advance to 1 ns after the next rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   // driver tasks
   task automatic do_write(input logic [2:0] a, input logic [W-1:0] d);
      addr  = a;
      wdata = d;
      we    = 1'b1;
      cyc();
      we    = 1'b0;
   endtask

   task automatic do_read(input logic [2:0] a, input logic [W-1:0] exp);
      addr = a;
      re   = 1'b1;
      exp_q.push_back(exp);
      cyc();
      re   = 1'b0;
   endtask

   // scoreboard monitor: compares every presented read against the queue
   always @(negedge clk) begin
      if (rvalid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL rvalid_unexpected: got rdata 0x%05h with no read pending", rdata);
         end else begin
            check("read_data", rdata, exp_q.pop_front());
         end
      end
   end

   initial begin
      rst   = 1'b1;
      addr  = '0;
      wdata = '0;
      we    = 1'b0;
      re    = 1'b0;
      pad_i = 20'hFFFFF;

      // 1. reset with pads high
      wait_cycles(3);
      check("rst_pad_o",  pad_o,  20'h0);
      check("rst_pad_oe", pad_oe, 20'h0);
      check("rst_irq",    {19'h0, irq},    20'h0);
      check("rst_rvalid", {19'h0, rvalid}, 20'h0);
      rst = 1'b0;
      wait_cycles(3);
      do_read(3'd5, 20'h00000);          // rise after sync fill, enables 0
      do_read(3'd2, 20'hFFFFF);
      check("post_rst_irq", {19'h0, irq}, 20'h0);
      pad_i = 20'h0;
      wait_cycles(4);
      do_read(3'd2, 20'h00000);

      // 2. output drive
      do_write(3'd1, 20'h0000F);
      check("pad_oe_after_write", pad_oe, 20'h0000F);
      check("pad_o_before_write", pad_o,  20'h00000);
      do_write(3'd0, 20'h00005);
      check("pad_o_after_write",  pad_o,  20'h00005);
      do_read(3'd1, 20'h0000F);
      do_read(3'd0, 20'h00005);

      // 3. input sync latency: pad changes before edge K
      pad_i = 20'h00080;
      do_read(3'd2, 20'h00000);          // sampled at edge K
      cyc();                             // edge K+1 idle
      do_read(3'd2, 20'h00080);          // sampled at edge K+2

      // 4. rise interrupt, ignored fall, write-1-to-clear
      pad_i = 20'h0;
      wait_cycles(4);
      do_write(3'd3, 20'h00080);
      pad_i = 20'h00080;
      wait_cycles(4);
      check("rise_irq", {19'h0, irq}, 20'h1);
      do_read(3'd5, 20'h00080);
      pad_i = 20'h0;
      wait_cycles(4);
      do_read(3'd5, 20'h00080);          // fall with FALL_EN = 0
      do_write(3'd5, 20'h00080);
      check("irq_lags_clear", {19'h0, irq}, 20'h1);
      cyc();
      check("irq_cleared", {19'h0, irq}, 20'h0);
      do_read(3'd5, 20'h00000);

      // 5. set and clear collide on bit 0
      do_write(3'd4, 20'h00001);
      pad_i = 20'h00001;
      wait_cycles(4);
      do_read(3'd5, 20'h00000);          // rise on bit 0 not enabled
      pad_i = 20'h0;                     // changes before edge Q1
      cyc();                             // after Q1
      cyc();                             // after Q2: fall visible this cycle
      do_write(3'd5, 20'h00001);         // clear sampled at Q3 with the set
      wait_cycles(2);
      check("collision_irq", {19'h0, irq}, 20'h1);
      do_read(3'd5, 20'h00001);
      do_write(3'd5, 20'h00001);
      wait_cycles(2);
      check("clear_irq", {19'h0, irq}, 20'h0);
      do_read(3'd5, 20'h00000);

      // 6. unmapped / read-only accesses
      pad_i = 20'hA5A5A;
      wait_cycles(4);
      do_write(3'd2, 20'hFFFFF);
      do_write(3'd6, 20'hFFFFF);
      do_write(3'd7, 20'hFFFFF);
      do_read(3'd2, 20'hA5A5A);
      do_read(3'd6, 20'h00000);
      do_read(3'd7, 20'h00000);
      do_read(3'd0, 20'h00005);
      do_read(3'd3, 20'h00080);
      check("pad_o_unchanged", pad_o, 20'h00005);
      addr  = 3'd0;
      wdata = 20'h12345;
      we    = 1'b1;
      re    = 1'b1;
      exp_q.push_back(20'h00005);        // read sees pre-write value
      cyc();
      we    = 1'b0;
      re    = 1'b0;
      do_read(3'd0, 20'h12345);
      check("pad_o_new", pad_o, 20'h12345);

      // reset during a pending read
      addr = 3'd1;
      re   = 1'b1;
      cyc();
      re   = 1'b0;
      check("rvalid_before_rst", {19'h0, rvalid}, 20'h1);
      #1 rst = 1'b1;
      #1;
      check("rvalid_async_drop", {19'h0, rvalid}, 20'h0);
      check("rst_pad_oe_mid",    pad_oe, 20'h0);
      check("rst_pad_o_mid",     pad_o,  20'h0);
      wait_cycles(2);
      rst = 1'b0;
      cyc();
      do_read(3'd1, 20'h00000);
      do_read(3'd0, 20'h00000);

      // drain the scoreboard with a bounded wait
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
      if (exp_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL read_timeout: got %0d reads outstanding expected 0", exp_q.size());
      end
      wait_cycles(2);

      // final report
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
